// File: rtl/pixel_frame_store_if.sv
// Pixel-plot bus between the drawing FSMs (master) and the frame store (slave).
// Carries plot writes and clear requests one way, and clear status plus the
// rejected-plot counter back.
interface pixel_frame_store_if;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [2:0] iColour;
  logic       iPlot;
  logic       iClear;
  logic       oBusy;
  logic       oDone;
  logic [7:0] oDropCount;

  modport master (
    output iX, iY, iColour, iPlot, iClear,
    input  oBusy, oDone, oDropCount
  );

  modport slave (
    input  iX, iY, iColour, iPlot, iClear,
    output oBusy, oDone, oDropCount
  );
endinterface

// File: rtl/pixel_frame_store.sv
// 3-bit-per-pixel frame store. Plots arrive over the pixel-plot bus, a
// clear sequencer wipes the memory after reset or on request, and a free
// running raster scanner streams the memory out as registered pixels.
module pixel_frame_store #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int H_BLANK         = 40,
  parameter int V_BLANK         = 5
) (
  input  logic                 iClock,
  input  logic                 iReset,
  pixel_frame_store_if.slave   plot,
  output logic [7:0]           oScanX,
  output logic [6:0]           oScanY,
  output logic [2:0]           oScanColour,
  output logic                 oScanValid,
  output logic                 oFrameStart
);

  localparam int NPIX    = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int ADDR_W  = 15;
  localparam int H_TOTAL = X_SCREEN_PIXELS + H_BLANK;
  localparam int V_TOTAL = Y_SCREEN_PIXELS + V_BLANK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  // Write side
  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [ADDR_W-1:0]   w_clr_addr_next;
  logic                r_done;
  logic                w_done_next;
  logic [7:0]          r_drop;
  logic [7:0]          w_drop_next;
  logic                w_in_range;
  logic                w_reject;
  logic [ADDR_W-1:0]   w_plot_addr;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [2:0]          w_wdata;

  // Frame memory
  logic [2:0]          r_mem [0:NPIX-1];

  // Scan side
  logic [H_W-1:0]      r_h;
  logic [V_W-1:0]      r_v;
  logic                w_h_last;
  logic                w_v_last;
  logic                w_scan_active;
  logic [ADDR_W-1:0]   w_raddr;
  logic [2:0]          r_rd_data;
  logic [7:0]          r_scan_x;
  logic [6:0]          r_scan_y;
  logic                r_scan_valid;
  logic                r_frame_start;

  // Full-width address math so out-of-range coordinates never alias onto
  // a valid pixel before the range check rejects them.
  assign w_in_range  = (int'(plot.iX) < X_SCREEN_PIXELS) &&
                       (int'(plot.iY) < Y_SCREEN_PIXELS);
  assign w_plot_addr = ADDR_W'(plot.iY) * ADDR_W'(X_SCREEN_PIXELS) + ADDR_W'(plot.iX);

  // Next-state, write-port steering and drop counting for the plot/clear FSM
  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_done_next     = 1'b0;
    w_drop_next     = r_drop;
    w_reject        = 1'b0;
    w_we            = 1'b0;
    w_waddr         = w_plot_addr;
    w_wdata         = plot.iColour;

    case (r_state)
      ST_CLEAR: begin
        // The clear owns the write port; any plot now is lost.
        w_we     = 1'b1;
        w_waddr  = r_clr_addr;
        w_wdata  = 3'd0;
        w_reject = plot.iPlot;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_next    = ST_IDLE;
          w_clr_addr_next = '0;
          w_done_next     = 1'b1;
        end else begin
          w_clr_addr_next = r_clr_addr + 1'b1;
        end
      end
      default: begin
        // A valid plot alongside a clear request still lands this edge.
        if (plot.iPlot && w_in_range) begin
          w_we = 1'b1;
        end else begin
          w_reject = plot.iPlot;
        end
        if (plot.iClear) begin
          w_state_next    = ST_CLEAR;
          w_clr_addr_next = '0;
        end
      end
    endcase

    if (w_reject && (r_drop != 8'hFF)) begin
      w_drop_next = r_drop + 8'd1;
    end
  end

  // FSM state, clear pointer, done pulse and drop counter registers
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_done     <= 1'b0;
      r_drop     <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
      r_done     <= w_done_next;
      r_drop     <= w_drop_next;
    end
  end

  assign plot.oBusy      = (r_state == ST_CLEAR);
  assign plot.oDone      = r_done;
  assign plot.oDropCount = r_drop;

  // Memory write port
  always_ff @(posedge iClock) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_h_last      = (r_h == H_W'(H_TOTAL - 1));
  assign w_v_last      = (r_v == V_W'(V_TOTAL - 1));
  assign w_scan_active = (int'(r_h) < X_SCREEN_PIXELS) && (int'(r_v) < Y_SCREEN_PIXELS);
  assign w_raddr       = ADDR_W'(r_v) * ADDR_W'(X_SCREEN_PIXELS) + ADDR_W'(r_h);

  // Raster counters, free running and independent of the write FSM
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Registered read port; old data wins on a same-cycle write, and blank
  // cycles read as colour 0
  always_ff @(posedge iClock) begin
    if (iReset || !w_scan_active) begin
      r_rd_data <= 3'd0;
    end else begin
      r_rd_data <= r_mem[w_raddr];
    end
  end

  // Scan position and flags delayed to line up with the read data
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_scan_x      <= 8'd0;
      r_scan_y      <= 7'd0;
      r_scan_valid  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_scan_x      <= w_scan_active ? 8'(r_h) : 8'd0;
      r_scan_y      <= w_scan_active ? 7'(r_v) : 7'd0;
      r_scan_valid  <= w_scan_active;
      r_frame_start <= (r_h == '0) && (r_v == '0);
    end
  end

  assign oScanX      = r_scan_x;
  assign oScanY      = r_scan_y;
  assign oScanColour = r_rd_data;
  assign oScanValid  = r_scan_valid;
  assign oFrameStart = r_frame_start;

endmodule

// File: tb/tb_pixel_frame_store.sv
// Directed bench for pixel_frame_store: clear timing, plot acceptance table,
// saturation, read-first scan behaviour, reset mid-clear and raster timing.
module tb_pixel_frame_store;

  localparam int XP    = 160;
  localparam int YP    = 120;
  localparam int HT    = 200;
  localparam int VT    = 125;
  localparam int NPIX  = XP * YP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;
  logic       scan_valid;
  logic       scan_fs;

  pixel_frame_store_if bus ();

  pixel_frame_store dut (
    .iClock      (clk),
    .iReset      (rst),
    .plot        (bus),
    .oScanX      (scan_x),
    .oScanY      (scan_y),
    .oScanColour (scan_colour),
    .oScanValid  (scan_valid),
    .oFrameStart (scan_fs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    int         exp_drop;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [2:0] exp_mem [0:NPIX-1];
  logic [2:0] cap     [0:NPIX-1];
  vec_t       vecs    [0:7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input int c, input bit p, input bit clr);
    bus.iX      = 8'(x);
    bus.iY      = 7'(y);
    bus.iColour = 3'(c);
    bus.iPlot   = p;
    bus.iClear  = clr;
  endtask

  // Starts on the negedge right after the reset edge; iClear is pulsed
  // mid-sequence to show it does not restart the count.
  task automatic measure_clear(input string tag);
    int busy_cnt = 0;
    int extra    = 0;
    int late_busy = 0;
    bit done     = 1'b0;
    for (int i = 0; i < 30000 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) check({tag, "_first_frame_start"}, int'(scan_fs), 1);
      if (bus.oDone) begin
        done = 1'b1;
        check({tag, "_busy_at_done"}, int'(bus.oBusy), 0);
      end else if (bus.oBusy) begin
        busy_cnt++;
      end
      bus.iClear = (i >= 100 && i < 200);
    end
    bus.iClear = 1'b0;
    check({tag, "_done_seen"}, int'(done), 1);
    check({tag, "_busy_cycles"}, busy_cnt, NPIX);
    @(negedge clk);
    check({tag, "_done_width"}, int'(bus.oDone), 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.oDone) extra++;
      if (bus.oBusy) late_busy++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_busy_after_done"}, late_busy, 0);
    $display("clear %s: busy=%0d cycles, done=%0d", tag, busy_cnt, done);
  endtask

  // Captures one whole frame starting at oFrameStart and checks raster order,
  // blanking, pixel contents against exp_mem and the frame period. With
  // do_rf set, colour 6 is written to (10,0) on the cycle that pixel is read.
  task automatic capture_frame(input bit do_rf, input string tag);
    bit found   = 1'b0;
    int pos_err = 0;
    int pix_err = 0;
    int nvalid  = 0;
    int ex_x, ex_y;
    bit act;
    for (int w = 0; w < 30000 && !found; w++) begin
      @(negedge clk);
      if (scan_fs) found = 1'b1;
    end
    check({tag, "_frame_start_found"}, int'(found), 1);
    if (found) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        ex_x = i % HT;
        ex_y = i / HT;
        act  = (ex_x < XP) && (ex_y < YP);
        if (scan_valid !== act) begin
          pos_err++;
        end else if (act) begin
          nvalid++;
          if (scan_x != 8'(ex_x) || scan_y != 7'(ex_y)) pos_err++;
          cap[ex_y * XP + ex_x] = scan_colour;
          if (scan_colour !== exp_mem[ex_y * XP + ex_x]) pix_err++;
        end else if (scan_x != 0 || scan_y != 0 || scan_colour != 0) begin
          pos_err++;
        end
        if (i > 0 && scan_fs) pos_err++;
        if (do_rf && i == 9)  drive(10, 0, 6, 1'b1, 1'b0);
        if (do_rf && i == 10) drive(0, 0, 0, 1'b0, 1'b0);
      end
      @(negedge clk);
      check({tag, "_frame_period"}, int'(scan_fs), 1);
      check({tag, "_raster_errors"}, pos_err, 0);
      check({tag, "_pixel_errors"}, pix_err, 0);
      check({tag, "_valid_cycles"}, nvalid, NPIX);
      $display("frame %s: valid=%0d raster_err=%0d pixel_err=%0d", tag, nvalid, pos_err, pix_err);
    end
  endtask

  initial begin
    int   ex_drop;
    bit   seen;
    int   seen_col;

    vecs[0] = '{x: 8'd5,   y: 7'd7,   c: 3'd3, p: 1'b1, exp_drop: 0};
    vecs[1] = '{x: 8'd160, y: 7'd0,   c: 3'd1, p: 1'b1, exp_drop: 1};
    vecs[2] = '{x: 8'd0,   y: 7'd120, c: 3'd2, p: 1'b1, exp_drop: 2};
    vecs[3] = '{x: 8'd255, y: 7'd127, c: 3'd7, p: 1'b1, exp_drop: 3};
    vecs[4] = '{x: 8'd159, y: 7'd119, c: 3'd5, p: 1'b1, exp_drop: 3};
    vecs[5] = '{x: 8'd0,   y: 7'd0,   c: 3'd4, p: 1'b1, exp_drop: 3};
    vecs[6] = '{x: 8'd20,  y: 7'd20,  c: 3'd7, p: 1'b0, exp_drop: 3};
    vecs[7] = '{x: 8'd200, y: 7'd5,   c: 3'd1, p: 1'b0, exp_drop: 3};

    for (int i = 0; i < NPIX; i++) exp_mem[i] = 3'd0;

    rst = 1'b1;
    drive(0, 0, 0, 1'b0, 1'b0);

    // Reset state right after the single reset edge
    @(negedge clk);
    check("rst_scan_valid",  int'(scan_valid), 0);
    check("rst_frame_start", int'(scan_fs), 0);
    check("rst_scan_x",      int'(scan_x), 0);
    check("rst_scan_y",      int'(scan_y), 0);
    check("rst_scan_colour", int'(scan_colour), 0);
    check("rst_busy",        int'(bus.oBusy), 1);
    check("rst_done",        int'(bus.oDone), 0);
    check("rst_drop",        int'(bus.oDropCount), 0);
    rst = 1'b0;
    measure_clear("init");

    // Plot acceptance table, applied back to back in IDLE
    for (int k = 0; k < 8; k++) begin
      drive(int'(vecs[k].x), int'(vecs[k].y), int'(vecs[k].c), vecs[k].p, 1'b0);
      if (vecs[k].p && vecs[k].x < 8'd160 && vecs[k].y < 7'd120)
        exp_mem[int'(vecs[k].y) * XP + int'(vecs[k].x)] = vecs[k].c;
      @(negedge clk);
      check($sformatf("vec%0d_drop", k), int'(bus.oDropCount), vecs[k].exp_drop);
      $display("vec %0d: x=%0d y=%0d c=%0d plot=%0d drop=%0d", k, vecs[k].x, vecs[k].y,
               vecs[k].c, vecs[k].p, bus.oDropCount);
    end
    drive(0, 0, 0, 1'b0, 1'b0);
    check("idle_after_plots", int'(bus.oBusy), 0);

    // Full frame with the plotted pixels, plus a read-first write at (10,0)
    capture_frame(1'b1, "f1");
    check("f1_pix_5_7",     int'(cap[7 * XP + 5]), 3);
    check("f1_pix_159_119", int'(cap[119 * XP + 159]), 5);
    check("f1_pix_0_0",     int'(cap[0]), 4);
    check("f1_pix_10_0_old", int'(cap[10]), 0);
    exp_mem[10] = 3'd6;

    // Following frame shows the new value at (10,0)
    seen     = 1'b0;
    seen_col = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (scan_valid && scan_x == 8'd10 && scan_y == 7'd0) begin
        seen     = 1'b1;
        seen_col = int'(scan_colour);
      end
    end
    check("f2_pix_10_0_seen", int'(seen), 1);
    check("f2_pix_10_0_new",  seen_col, 6);

    // Clear request with a simultaneous valid plot: written, not dropped
    ex_drop = 3;
    drive(30, 30, 2, 1'b1, 1'b1);
    @(negedge clk);
    check("clear_req_busy",    int'(bus.oBusy), 1);
    check("clear_plot_nodrop", int'(bus.oDropCount), ex_drop);

    // Valid plot while busy is rejected
    drive(1, 1, 1, 1'b1, 1'b0);
    @(negedge clk);
    ex_drop++;
    check("busy_plot_drop", int'(bus.oDropCount), ex_drop);

    // 300 further bad plots saturate the counter
    drive(255, 127, 7, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ex_drop < 255) ex_drop++;
    end
    drive(0, 0, 0, 1'b0, 1'b0);
    check("drop_saturated", int'(bus.oDropCount), ex_drop);
    check("drop_saturated_255", int'(bus.oDropCount), 255);
    $display("drops: count=%0d after 300 bad plots", bus.oDropCount);

    // Reset near clear cycle 5000 restarts the whole sequence
    repeat (5000 - 302) @(negedge clk);
    check("midclear_busy", int'(bus.oBusy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_drop",       int'(bus.oDropCount), 0);
    check("midrst_busy",       int'(bus.oBusy), 1);
    check("midrst_scan_valid", int'(scan_valid), 0);
    rst = 1'b0;
    measure_clear("midrst");
    check("final_drop", int'(bus.oDropCount), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_frame_store.md
Name: pixel_frame_store

Overview:
- Receiving end of the pixel-plot interface driven by the box/screen drawing FSMs: accepts (X, Y, colour, plot) writes into an internal 3-bit-per-pixel frame memory.
- Continuously raster-scans the memory and emits a registered pixel stream for the display stage.
- Owns a screen-clear sequencer that runs on reset and on request.
- Sits between the drawing FSMs and the VGA output stage.

Parameters:
X_SCREEN_PIXELS, 160, active pixels per line
Y_SCREEN_PIXELS, 120, active lines per frame
H_BLANK, 40, blank cycles appended to each line
V_BLANK, 5, blank lines appended to each frame

Ports:
iClock  input  1  system clock, all logic on rising edge
iReset  input  1  synchronous, active-high reset
iX  input  8  plot X coordinate
iY  input  7  plot Y coordinate
iColour  input  3  plot colour
iPlot  input  1  write strobe, one pixel per cycle high
iClear  input  1  request full-screen clear to colour 0
oBusy  output  1  clear sequence in progress
oDone  output  1  one-cycle pulse when a clear completes
oDropCount  output  8  saturating count of rejected plots
oScanX  output  8  X of pixel on oScanColour
oScanY  output  7  Y of pixel on oScanColour
oScanColour  output  3  pixel colour read from memory
oScanValid  output  1  oScan* carry an active pixel
oFrameStart  output  1  high with pixel (0,0) of each frame

Behaviour:
- Memory: X_SCREEN_PIXELS*Y_SCREEN_PIXELS entries of 3 bits. Address = y*X_SCREEN_PIXELS + x, 15 bits, computed without truncation.
- One write port and one read port. Read is synchronous, 1-cycle latency.
- Same-address same-cycle read/write is read-first: the old value is returned.

Write FSM, states IDLE and CLEAR:
- Reset enters CLEAR, with clear address 0, oBusy=1, oDone=0 and oDropCount=0.
- CLEAR writes colour 0 to clear address A each cycle, then increments A.
- After writing A = X*Y-1, the next state is IDLE and oDone pulses for exactly 1 cycle on the first IDLE cycle. oBusy is low from that cycle.
- Total time in CLEAR is X*Y cycles.
- IDLE with iClear=1 goes to CLEAR on the next edge with A=0. oBusy rises on that edge.
- iClear while in CLEAR is ignored; the count does not restart.
- Reset mid-clear restarts the clear from A=0.

Plot acceptance:
- In IDLE, an iPlot=1 with iX<X_SCREEN_PIXELS and iY<Y_SCREEN_PIXELS writes iColour on that edge.
- A plot is rejected if it is out of range, or if iPlot=1 arrives in CLEAR.
- Each rejected plot increments oDropCount by 1, saturating at 255.
- Simultaneous iClear and valid iPlot in IDLE: the plot is written on that edge, then CLEAR begins.

Scan:
- Counters h (0..X+H_BLANK-1) and v (0..Y+V_BLANK-1) advance every cycle, independent of the write FSM and of clearing.
- h wraps to 0 and increments v; v wraps at Y+V_BLANK-1 to 0.
- Reset sets h=v=0.
- A read address is issued when h<X and v<Y.
- All oScan* outputs are registered 1 cycle after the address: oScanX/oScanY equal the delayed h/v, and oScanValid is the delayed active flag.
- oFrameStart is the delayed (h==0 && v==0).
- When oScanValid=0: oScanColour=0, oScanX=0, oScanY=0.
- During reset, all scan outputs are 0. The first oFrameStart arrives 1 cycle after reset deasserts.

Test Plan:
- Reset 1 cycle, then release -> oBusy=1 for exactly 19200 cycles, oDone pulses once, oBusy=0 on that cycle; the next full frame scans all 19200 pixels with oScanColour=0.
- After the clear completes, plot (5,7) colour 3 -> in the next frame, the cycle with oScanX=5, oScanY=7 has oScanColour=3, and every other active pixel reads 0.
- Plot (160,0), (0,120) and (255,127) in IDLE, plus one valid plot while oBusy=1 -> oDropCount=4 and memory is unchanged. Drive 300 bad plots -> oDropCount holds at 255.
- Write colour 6 to (10,0) on the exact cycle its address is read -> that frame shows the old value 0 at (10,0); the following frame shows 6.
- Issue iClear, assert iReset at clear cycle 5000, then release -> oBusy stays high for 19200 cycles after the release, a single oDone pulse follows, and oDropCount=0.
- Check scan timing: oFrameStart period is (160+40)*(120+5)=25000 cycles; oScanValid is high for 160 consecutive cycles per line across 120 lines, then low for 5 lines.
